// File: rtl/serial_arith_pkg.sv
// Shared opcode and FSM encodings for the bit-serial arithmetic controller.
// Imported by the slice, the controller and the bench.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_RSUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_arith_ctrl_if.sv
// Request/response bundle between a requester and serial_arith_ctrl.
// The requester side is the master.
interface serial_arith_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             zero;

  modport master (
    output start, sel, a, b, ci,
    input  busy, done, result, co, zero
  );

  modport slave (
    input  start, sel, a, b, ci,
    output busy, done, result, co, zero
  );
endinterface

// File: rtl/alu_bit_slice.sv
// One-bit full-adder slice with per-opcode operand inversion.
// Purely combinational; the controller owns the carry chain.
module alu_bit_slice
  import serial_arith_pkg::*;
(
  input  logic [1:0] sel,
  input  logic       a,
  input  logic       b,
  input  logic       ci,
  output logic       g,
  output logic       co
);

  logic w_x;
  logic w_y;

  always_comb begin
    w_x = a;
    w_y = b;
    unique case (op_e'(sel))
      OP_INC:  w_y = 1'b0;
      OP_ADD:  w_y = b;
      OP_SUB:  w_y = ~b;
      OP_RSUB: w_x = ~a;
    endcase
  end

  assign g  = w_x ^ w_y ^ ci;
  assign co = (w_x & w_y) | (ci & (w_x ^ w_y));

endmodule

// File: rtl/serial_arith_ctrl.sv
// Bit-serial add/sub controller: one bit per cycle, LSB first.
// Output registers change only when an operation completes or on reset.
module serial_arith_ctrl
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_arith_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           r_state;
  state_e           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_sel;
  logic             r_c;
  logic [WIDTH-1:0] r_res;
  logic             r_co;

  logic             w_g;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_acc;

  alu_bit_slice u_slice (
    .sel (r_sel),
    .a   (r_a[0]),
    .b   (r_b[0]),
    .ci  (r_c),
    .g   (w_g),
    .co  (w_co)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  // r_a doubles as the accumulator: bit cnt lands at position cnt
  assign w_acc  = {w_g, r_a[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_sel <= '0;
      r_c   <= 1'b0;
      r_res <= '0;
      r_co  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.start) begin
          r_a   <= bus.a;
          r_b   <= bus.b;
          r_sel <= bus.sel;
          r_c   <= bus.ci;
          r_cnt <= '0;
        end
        S_RUN: begin
          r_a   <= w_acc;
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_c   <= w_co;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_res <= w_acc;
            r_co  <= w_co;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy   = (r_state == S_RUN) || (r_state == S_DONE);
    bus.done   = (r_state == S_DONE);
    bus.result = r_res;
    bus.co     = r_co;
    bus.zero   = (r_res == '0);
  end

endmodule

// File: tb/tb_serial_arith_ctrl.sv
// Directed bench for serial_arith_ctrl at WIDTH=8.
// Expected values are hand-computed constants.
module tb_serial_arith_ctrl;
  import serial_arith_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  logic [7:0] last_r;
  logic       last_co;
  logic       last_z;

  serial_arith_ctrl_if #(.WIDTH(8)) bus ();

  serial_arith_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [1:0] s,
                        input logic [7:0] av,
                        input logic [7:0] bv,
                        input logic c,
                        input logic [7:0] er,
                        input logic ec,
                        input logic ez,
                        input bit poke);
    int cyc;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel   = s;
    bus.a     = av;
    bus.b     = bv;
    bus.ci    = c;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      bus.start = poke && (cyc == 3);
      bus.sel   = 2'($urandom);
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
      bus.ci    = 1'($urandom);
      if (bus.done) seen = 1'b1;
      else if (cyc == 5) begin
        chk({tag, " busy_run"}, bus.busy, 1);
        chk({tag, " hold_r"}, bus.result, last_r);
        chk({tag, " hold_co"}, bus.co, last_co);
        chk({tag, " hold_z"}, bus.zero, last_z);
      end
    end
    chk({tag, " latency"}, cyc, 9);
    chk({tag, " result"}, bus.result, er);
    chk({tag, " co"}, bus.co, ec);
    chk({tag, " zero"}, bus.zero, ez);
    chk({tag, " busy_done"}, bus.busy, 1);
    bus.start = poke;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, " done_pulse"}, bus.done, 0);
    chk({tag, " busy_idle"}, bus.busy, 0);
    chk({tag, " held_r"}, bus.result, er);
    if (poke) begin
      repeat (3) @(negedge clk);
      chk({tag, " no_requeue"}, bus.busy, 0);
    end
    last_r  = er;
    last_co = ec;
    last_z  = ez;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    bus.start = 1'b0;
    bus.sel   = 2'b00;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.ci    = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst result", bus.result, 0);
    chk("rst co", bus.co, 0);
    chk("rst zero", bus.zero, 1);
    rst     = 1'b0;
    last_r  = 8'h00;
    last_co = 1'b0;
    last_z  = 1'b1;

    run_op("add", OP_ADD, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0);
    run_op("sub", OP_SUB, 8'h3C, 8'h5A, 1'b1, 8'hE2, 1'b0, 1'b0, 1'b0);
    run_op("inc", OP_INC, 8'hFF, 8'h77, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("rsub", OP_RSUB, 8'h01, 8'h05, 1'b1, 8'h04, 1'b1, 1'b0, 1'b1);

    // abort in RUN cycle 4
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel   = OP_ADD;
    bus.a     = 8'h11;
    bus.b     = 8'h22;
    bus.ci    = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy_before", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", bus.busy, 0);
    chk("abort result", bus.result, 0);
    chk("abort zero", bus.zero, 1);
    chk("abort co", bus.co, 0);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort no_done", dones, 0);
    last_r  = 8'h00;
    last_co = 1'b0;
    last_z  = 1'b1;

    run_op("post", OP_ADD, 8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0, 1'b0);
    run_op("subeq", OP_SUB, 8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
